// File: rtl/rv_ctrl_pkg.sv
// Shared control definitions for the RV32I core: opcodes, FSM states,
// datapath select encodings and the opcode class used by the decoders.
package rv_ctrl_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] RTypeI = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam int unsigned WAIT_W = 8;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } mc_state_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_ALU   = 2'd2
  } pc_src_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  typedef enum logic [1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_ZERO = 2'd2
  } alu_src_a_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASS  = 2'b11;

  typedef enum logic [3:0] {
    CL_R     = 4'd0,
    CL_I     = 4'd1,
    CL_LW    = 4'd2,
    CL_SW    = 4'd3,
    CL_BR    = 4'd4,
    CL_LUI   = 4'd5,
    CL_AUIPC = 4'd6,
    CL_JAL   = 4'd7,
    CL_JALR  = 4'd8,
    CL_ILL   = 4'd9
  } op_class_t;

endpackage

// File: rtl/mc_control_fsm_opcode_class.sv
// Combinational opcode-to-class decode with a legal flag; shared by the
// multi-cycle controller and the hazard unit.
module opcode_class
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [3:0] op_class,
  output logic       legal
);

  always_comb begin
    op_class = CL_ILL;
    case (opcode)
      R_TYPE:  op_class = CL_R;
      RTypeI:  op_class = CL_I;
      LW:      op_class = CL_LW;
      SW:      op_class = CL_SW;
      BR:      op_class = CL_BR;
      LUI:     op_class = CL_LUI;
      AUIPC:   op_class = CL_AUIPC;
      JAL:     op_class = CL_JAL;
      JALR:    op_class = CL_JALR;
      default: op_class = CL_ILL;
    endcase
    legal = (op_class != CL_ILL);
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I sequencing controller: FETCH/DECODE/EXEC/MEM/WB over a
// shared memory port, with a memory-wait timeout and a retired-instruction counter.
module mc_control_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 16,
  parameter int unsigned RET_CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           Opcode,
  input  logic                 br_taken,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 ir_write,
  output logic                 iord,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic [1:0]           alu_src_a,
  output logic                 alu_src_b,
  output logic [1:0]           ALUOp,
  output logic                 retire,
  output logic [RET_CNT_W-1:0] ret_count,
  output logic                 trap,
  output logic [2:0]           state_o
);

  mc_state_t         state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [3:0]        cls_raw;
  op_class_t         cls;
  logic              legal;
  logic              timeout_c;

  opcode_class u_opcode_class (
    .opcode   (Opcode),
    .op_class (cls_raw),
    .legal    (legal)
  );

  assign cls       = op_class_t'(cls_raw);
  // A ready in the final allowed cycle still wins over the timeout.
  assign timeout_c = !mem_ready && (wait_cnt == WAIT_W'(MEM_WAIT_MAX - 1));
  assign trap      = (state == TRAP);
  assign state_o   = state;

  // State, wait counter and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      wait_cnt  <= '0;
      ret_count <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        wait_cnt <= '0;
      else if ((state == FETCH || state == MEM) && !mem_ready)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (retire)
        ret_count <= ret_count + RET_CNT_W'(1);
    end
  end

  // Next state and Moore control decode.
  always_comb begin
    state_nxt = state;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    ir_write  = 1'b0;
    iord      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;
    alu_src_a = A_RS1;
    alu_src_b = 1'b0;
    ALUOp     = ALUOP_ADD;
    retire    = 1'b0;
    case (state)
      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = DECODE;
        end else if (timeout_c) begin
          state_nxt = TRAP;
        end
      end
      DECODE: state_nxt = legal ? EXEC : TRAP;
      EXEC: begin
        state_nxt = WB;
        case (cls)
          CL_R:  ALUOp = ALUOP_FUNCT;
          CL_I: begin
            alu_src_b = 1'b1;
            ALUOp     = ALUOP_FUNCT;
          end
          CL_LW, CL_SW: begin
            alu_src_b = 1'b1;
            state_nxt = MEM;
          end
          CL_LUI: begin
            alu_src_a = A_ZERO;
            alu_src_b = 1'b1;
            ALUOp     = ALUOP_PASS;
          end
          CL_AUIPC: begin
            alu_src_a = A_PC;
            alu_src_b = 1'b1;
            ALUOp     = ALUOP_PASS;
          end
          CL_BR: begin
            ALUOp     = ALUOP_BR;
            pc_write  = br_taken;
            pc_src    = PC_IMM;
            retire    = 1'b1;
            state_nxt = FETCH;
          end
          CL_JAL: begin
            pc_write = 1'b1;
            pc_src   = PC_IMM;
            ALUOp    = ALUOP_PASS;
          end
          CL_JALR: begin
            alu_src_b = 1'b1;
            pc_write  = 1'b1;
            pc_src    = PC_ALU;
            ALUOp     = ALUOP_PASS;
          end
          default: state_nxt = TRAP;
        endcase
      end
      MEM: begin
        iord      = 1'b1;
        mem_read  = (cls == CL_LW);
        mem_write = (cls == CL_SW);
        if (mem_ready) begin
          retire    = (cls == CL_SW);
          state_nxt = (cls == CL_SW) ? FETCH : WB;
        end else if (timeout_c) begin
          state_nxt = TRAP;
        end
      end
      WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        if (cls == CL_LW)
          wb_sel = WB_MEM;
        else if (cls == CL_JAL || cls == CL_JALR)
          wb_sel = WB_PC4;
        state_nxt = FETCH;
      end
      TRAP:    state_nxt = TRAP;
      default: state_nxt = FETCH;
    endcase
    // Reset abandons any access immediately and keeps every control quiet.
    if (reset) begin
      pc_write  = 1'b0;
      pc_src    = PC_PLUS4;
      ir_write  = 1'b0;
      iord      = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      wb_sel    = WB_ALU;
      alu_src_a = A_RS1;
      alu_src_b = 1'b0;
      ALUOp     = ALUOP_ADD;
      retire    = 1'b0;
    end
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle sequencing controller for the RV32I core datapath. Drives one instruction through FETCH, DECODE, EXEC, MEM and WB over several cycles.
- Shares a single memory port between instruction fetch and data access using a ready handshake.
- Used in the multi-cycle build in place of the single-cycle opcode decoder.
- Supports the opcode set R, I-ALU, LW, SW, BR, LUI, AUIPC, JAL and JALR. Any other opcode traps.

Parameters:
- MEM_WAIT_MAX, 16: maximum cycles to wait for mem_ready before trapping. Legal range 1..255.
- RET_CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- Opcode  input  7  opcode field from the instruction register. Valid from DECODE onward.
- br_taken  input  1  branch comparator result from the ALU. Sampled in EXEC.
- mem_ready  input  1  memory has completed the current access (read data valid / write accepted).
- pc_write  output  1  load PC.
- pc_src  output  2  PC source: 0 = PC+4, 1 = PC+imm (branch/JAL), 2 = ALU result & ~1 (JALR).
- ir_write  output  1  load instruction register.
- iord  output  1  memory address select: 0 = PC, 1 = ALU result.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- reg_write  output  1  register file write enable.
- wb_sel  output  2  write-back source: 0 = ALU, 1 = memory data, 2 = PC+4.
- alu_src_a  output  2  ALU operand A: 0 = rs1, 1 = PC, 2 = zero.
- alu_src_b  output  1  ALU operand B: 0 = rs2, 1 = immediate.
- ALUOp  output  2  ALU decoder class, same encoding as the single-cycle decoder: 00 = add, 01 = branch compare, 10 = funct-decoded, 11 = pass/add (LUI/AUIPC/JAL/JALR).
- retire  output  1  one-cycle pulse when an instruction completes.
- ret_count  output  RET_CNT_W  count of retired instructions.
- trap  output  1  sticky; set on an illegal opcode or a memory timeout.
- state_o  output  3  current state, for debug.

Behaviour:
- Reset: state = FETCH; wait counter = 0; ret_count = 0; trap = 0.
  - All strobes are 0.
  - pc_src, wb_sel, alu_src_a, alu_src_b and ALUOp are 0.
- Reset is synchronous and wins over every other event, including asserting mid-access. Any in-flight access is abandoned and mem_read/mem_write drop on the next edge.
- All outputs are a registered or pure Moore decode of the state plus Opcode and br_taken. No output depends combinationally on mem_ready, except that the FETCH and MEM completion strobes are qualified by mem_ready.
- FETCH:
  - iord = 0, mem_read = 1, held for the whole state.
  - When mem_ready = 1: ir_write = 1 and pc_write = 1 with pc_src = 0 in the same cycle, then go to DECODE.
- DECODE:
  - One cycle. All strobes are 0.
  - Unknown opcode: go to TRAP. Otherwise go to EXEC.
- EXEC, one cycle, operands and next state per class:
  - R-type: a = rs1, b = rs2, ALUOp = 10. Next: WB.
  - I-ALU: a = rs1, b = imm, ALUOp = 10. Next: WB.
  - LW / SW: a = rs1, b = imm, ALUOp = 00. Next: MEM.
  - LUI: a = zero, b = imm, ALUOp = 11. Next: WB.
  - AUIPC: a = PC, b = imm, ALUOp = 11. Next: WB. (PC here is the old PC held by the datapath's oldPC register.)
  - BR: a = rs1, b = rs2, ALUOp = 01. pc_write = br_taken, pc_src = 1. retire = 1. Next: FETCH.
  - JAL: pc_write = 1, pc_src = 1, ALUOp = 11. Next: WB.
  - JALR: a = rs1, b = imm, pc_write = 1, pc_src = 2, ALUOp = 11. Next: WB.
- MEM:
  - iord = 1; mem_read = 1 for LW, mem_write = 1 for SW; held until mem_ready.
  - On mem_ready: LW goes to WB; SW pulses retire and goes to FETCH.
- WB:
  - One cycle. reg_write = 1, retire = 1.
  - wb_sel = 1 for LW, 2 for JAL/JALR, 0 otherwise.
  - Next: FETCH.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle mem_ready = 0 in those states.
  - Reaching MEM_WAIT_MAX without mem_ready: go to TRAP.
  - mem_ready arriving in the same cycle the counter hits the limit counts as success, not timeout.
- TRAP:
  - All strobes are 0; trap = 1.
  - Terminal until reset.
- retire and ret_count:
  - ret_count increments on each retire pulse.
  - It wraps modulo 2^RET_CNT_W with no saturation.
- Cycle counts with zero-wait memory:
  - R/I/LUI/AUIPC/JAL/JALR/LW(WB path): FETCH 1 + DECODE 1 + EXEC 1 + WB 1 = 4 cycles, plus MEM 1 for LW = 5.
  - SW: 4 cycles.
  - BR: 3 cycles.
- mem_read and mem_write are never both 1. ir_write is only ever 1 in FETCH.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode localparams (R_TYPE, LW, SW, RTypeI, BR, LUI, JAL, JALR, AUIPC);
  - the state enum mc_state_t (FETCH, DECODE, EXEC, MEM, WB, TRAP);
  - enums for pc_src, wb_sel and alu_src_a;
  - the ALUOp class constants.
- One sub-module, opcode_class: a combinational opcode-to-class decode plus legal flag, reused by this block and by the hazard unit.
- The FSM, wait counter and retire counter stay in this module.

Test Plan:
- ADDI (opcode 0010011), mem_ready always 1 -> states FETCH, DECODE, EXEC, WB. reg_write only in cycle 4. ALUOp = 10, alu_src_b = 1. retire pulses once. ret_count = 1.
- LW with mem_ready delayed 3 cycles in both FETCH and MEM -> mem_read held 4 cycles in each. iord = 0 then 1. WB has wb_sel = 1. Total 11 cycles.
- BEQ with br_taken = 1, then again with br_taken = 0 -> 3 cycles each. pc_write = 1 with pc_src = 1 only in the taken case. retire pulses both times.
- JALR -> EXEC has pc_write = 1, pc_src = 2. WB has reg_write = 1, wb_sel = 2.
- Opcode 7'b1111111 -> TRAP after DECODE. trap stays 1 for 20 cycles and all strobes stay 0. Reset then returns to FETCH with trap = 0.
- MEM_WAIT_MAX = 4:
  - mem_ready never asserted in FETCH -> TRAP after 4 wait cycles.
  - mem_ready in exactly the 4th cycle -> proceeds to DECODE.
  - Reset asserted mid-MEM on an SW -> mem_write = 0 on the next edge and state = FETCH.
